// File: rtl/pll_seq_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_seq_timer.sv
// Loadable down-counter shared by every timed phase; done_c flags the final cycle of a phase.
module pll_seq_timer #(
  parameter int unsigned W       = 12,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk_in_n,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_in_n or posedge reset) begin
    if (reset) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock / staged domain-release sequencer.
// Define PLL_SEQ_TIMEOUT_EN to enable lock timeout, retries and the FAIL state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 5,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 2048,
  parameter int unsigned STABLE_CYCLES  = 64,
  parameter int unsigned RELEASE_GAP    = 8,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                   clk_in_n,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   restart_req,
  input  logic                   clr_lost,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   ready,
  output logic                   pll_fail,
  output logic                   lock_lost,
  output logic [RETRY_W-1:0]     retry_count
);

  localparam int unsigned TMR_MAX  = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                           max_u(STABLE_CYCLES, RELEASE_GAP));
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS == 0 || PLL_RST_CYCLES == 0 || LOCK_TIMEOUT == 0 ||
      STABLE_CYCLES == 0 || RELEASE_GAP == 0 || MAX_RETRIES == 0 ||
      MAX_RETRIES > ((1 << RETRY_W) - 1)) begin : g_bad_params
    $error("pll_reset_sequencer: illegal parameter value");
  end

  seq_state_e               state_q, state_d;
  logic [IDX_W-1:0]         rel_idx_q, rel_idx_d;
  logic                     pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0]   domain_reset_q, domain_reset_d;
  logic                     ready_q, ready_d;
  logic                     pll_fail_q, pll_fail_d;
  logic                     lock_lost_q, lock_lost_d;
  logic [RETRY_W-1:0]       retry_count_q, retry_count_d;

  logic                     tmr_load;
  logic [TMR_W-1:0]         tmr_val;
  logic                     tmr_done_c;
  logic                     loss;

  pll_seq_timer #(
    .W       (TMR_W),
    .RST_VAL (PLL_RST_CYCLES - 1)
  ) u_timer (
    .clk_in_n (clk_in_n),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  // Next state, phase timer control and registered output values.
  always_comb begin
    state_d        = state_q;
    rel_idx_d      = rel_idx_q;
    domain_reset_d = domain_reset_q;
    retry_count_d  = retry_count_q;
    lock_lost_d    = lock_lost_q;
    tmr_load       = 1'b0;
    tmr_val        = '0;
    loss           = 1'b0;

    case (state_q)
      PLL_RST: begin
        if (tmr_done_c) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked) begin
          state_d = STABLE;
        end
`ifdef PLL_SEQ_TIMEOUT_EN
        else if (tmr_done_c) begin
          retry_count_d = (retry_count_q == '1) ? retry_count_q : retry_count_q + RETRY_W'(1);
          state_d       = (32'(retry_count_d) >= MAX_RETRIES) ? FAIL : PLL_RST;
        end
`endif
      end
      STABLE: begin
        if (!locked) begin
          loss    = 1'b1;
          state_d = PLL_RST;
        end else if (tmr_done_c) begin
          rel_idx_d         = '0;
          domain_reset_d[0] = 1'b0;
          state_d           = (NUM_DOMAINS == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        if (!locked) begin
          loss    = 1'b1;
          state_d = PLL_RST;
        end else if (tmr_done_c) begin
          rel_idx_d      = rel_idx_q + IDX_W'(1);
          domain_reset_d = domain_reset_q & ~(NUM_DOMAINS'(1) << rel_idx_d);
          if (rel_idx_d == LAST_IDX) begin
            state_d = RUN;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(RELEASE_GAP - 1);
          end
        end
      end
      RUN: begin
        if (!locked) begin
          loss    = 1'b1;
          state_d = PLL_RST;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: state_d = PLL_RST;
    endcase

    // Restart outranks every other transition, including a simultaneous loss.
    if (restart_req && state_q != PLL_RST) begin
      state_d       = PLL_RST;
      retry_count_d = '0;
    end

    if (state_d != state_q) begin
      tmr_load = 1'b1;
      case (state_d)
        PLL_RST:   tmr_val = TMR_W'(PLL_RST_CYCLES - 1);
        WAIT_LOCK: tmr_val = TMR_W'(LOCK_TIMEOUT - 1);
        STABLE:    tmr_val = TMR_W'(STABLE_CYCLES - 1);
        RELEASE:   tmr_val = TMR_W'(RELEASE_GAP - 1);
        default:   tmr_val = '0;
      endcase
    end

    if (state_d == PLL_RST || state_d == FAIL) begin
      domain_reset_d = '1;
      rel_idx_d      = '0;
    end
    if (state_d == RUN) retry_count_d = '0;

    if (loss) begin
      lock_lost_d = 1'b1;
    end else if (clr_lost) begin
      lock_lost_d = 1'b0;
    end

    pll_reset_d = (state_d == PLL_RST);
    ready_d     = (state_d == RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
    pll_fail_d  = (state_d == FAIL);
`else
    pll_fail_d    = 1'b0;
    retry_count_d = '0;
`endif
  end

  always_ff @(posedge clk_in_n or posedge reset) begin
    if (reset) begin
      state_q        <= PLL_RST;
      rel_idx_q      <= '0;
      pll_reset_q    <= 1'b1;
      domain_reset_q <= '1;
      ready_q        <= 1'b0;
      pll_fail_q     <= 1'b0;
      lock_lost_q    <= 1'b0;
      retry_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      rel_idx_q      <= rel_idx_d;
      pll_reset_q    <= pll_reset_d;
      domain_reset_q <= domain_reset_d;
      ready_q        <= ready_d;
      pll_fail_q     <= pll_fail_d;
      lock_lost_q    <= lock_lost_d;
      retry_count_q  <= retry_count_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign domain_reset = domain_reset_q;
  assign ready        = ready_q;
  assign pll_fail     = pll_fail_q;
  assign lock_lost    = lock_lost_q;
  assign retry_count  = retry_count_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 5: number of output clock domains sequenced.
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16: pll_reset pulse width in cycles.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 2048: cycles allowed in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter STABLE_CYCLES, default 64: cycles locked must stay high before release.
REQ-005 SHALL have parameter RELEASE_GAP, default 8: cycles between successive domain reset releases.
REQ-006 SHALL have parameter MAX_RETRIES, default 3: lock attempts allowed before FAIL.
REQ-007 SHALL have port clk_in_n  input  1  clock; all logic on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high block reset.
REQ-009 SHALL have port locked  input  1  PLL lock indication, synchronous to clk_in_n.
REQ-010 SHALL have port restart_req  input  1  single-cycle request to re-run the full sequence.
REQ-011 SHALL have port clr_lost  input  1  clears the sticky lock_lost flag.
REQ-012 SHALL have port pll_reset  output  1  reset to the PLL, active-high.
REQ-013 SHALL have port domain_reset  output  NUM_DOMAINS  per-domain reset, active-high.
REQ-014 SHALL have port ready  output  1  high only in RUN.
REQ-015 SHALL have port pll_fail  output  1  high only in FAIL.
REQ-016 SHALL have port lock_lost  output  1  sticky: locked dropped while in STABLE, RELEASE or RUN.
REQ-017 SHALL have port retry_count  output  2  completed failed lock attempts, saturating.

Function
REQ-018 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.
REQ-019 PLL_RST: pll_reset high for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK; pll_reset low in every other state.
REQ-020 WAIT_LOCK: locked high -> STABLE next cycle; LOCK_TIMEOUT cycles elapsed without lock -> increment retry_count, then PLL_RST, or FAIL if retry_count reaches MAX_RETRIES.
REQ-021 STABLE: locked held high for STABLE_CYCLES consecutive cycles -> RELEASE; any low cycle -> PLL_RST.
REQ-022 RELEASE: deassert domain_reset[0] on entry, then bit i after another RELEASE_GAP cycles, ascending index; after the last bit -> RUN.
REQ-023 Released bits SHALL stay low until a return to PLL_RST; bits not yet released SHALL stay high.
REQ-024 RUN: ready high; retry_count cleared to 0 on entry.
REQ-025 Loss: locked low in RELEASE or RUN -> all domain_reset high and ready low on the next cycle, lock_lost set, then PLL_RST.
REQ-026 restart_req in any state except PLL_RST -> all domain_reset high, retry_count 0, then PLL_RST; ignored in PLL_RST.
REQ-027 FAIL: all domain_reset high, pll_reset low, held until restart_req or reset.
REQ-028 restart_req in the same cycle as a lock loss SHALL take priority; lock_lost is still set.
REQ-029 clr_lost in the same cycle as a new loss SHALL leave lock_lost set.
REQ-030 retry_count SHALL saturate at 3.

Reset
REQ-031 reset SHALL force state PLL_RST, phase counter 0, pll_reset 1, domain_reset all 1s, ready 0, pll_fail 0, lock_lost 0, retry_count 0.
REQ-032 Reset deassertion SHALL start a full PLL_RST pulse of PLL_RST_CYCLES cycles.
REQ-033 Reset asserted mid-sequence SHALL abort it with no partial release.

Configuration
REQ-034 Macro PLL_SEQ_TIMEOUT_EN defined: lock timeout, retries, FAIL and pll_fail are active as specified.
REQ-035 Macro PLL_SEQ_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely, FAIL is unreachable, pll_fail is tied 0 and retry_count is tied 0.

Structure
REQ-036 Package pll_seq_pkg SHALL hold the state enum typedef and the retry_count width constant.
REQ-037 One sub-module, pll_seq_timer, SHALL provide a loadable down-counter with done flag, shared across all timed states.

Verification
REQ-038 Reset released, locked rises 1499 cycles after pll_reset falls -> STABLE, release bits 0..4 at 8-cycle spacing, ready 64+32 cycles after lock.
REQ-039 locked never rises -> 3 timeouts of 2048 cycles each, retry_count=3, pll_fail=1; restart_req -> PLL_RST, retry_count=0.
REQ-040 locked dropped in RUN -> domain_reset=5'b11111 next cycle, lock_lost=1, pll_reset pulse of 16 cycles; clr_lost -> lock_lost=0.
REQ-041 locked glitches low at STABLE cycle 30 -> back to PLL_RST, no domain_reset bit released.
REQ-042 reset asserted after 2 domains are released -> all outputs at reset values immediately.
REQ-043 Build without PLL_SEQ_TIMEOUT_EN, no lock for 10000 cycles -> still in WAIT_LOCK, pll_fail=0.
